// File: rtl/pipeline_pkg.sv
// Shared pipeline types: control bundle, result-select encoding and the NOP bundle.
package pipeline_pkg;

  localparam int unsigned ALU_CTRL_W = 4;

  typedef enum logic [1:0] {
    RESULT_ALU      = 2'd0,
    RESULT_MEM      = 2'd1,
    RESULT_PC_PLUS4 = 2'd2
  } result_src_t;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic                  alu_src;
    result_src_t           result_src;
    logic [ALU_CTRL_W-1:0] alu_control;
  } ctrl_t;

  localparam ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/operand_bypass.sv
// Per-operand select: x0 forces zero; with DECODE_EXECUTE_WB_BYPASS_EN a same-cycle
// write-back to the read index replaces the register file data.
module operand_bypass #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic [ADDRESS_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0]    rd,
  input  logic                     reg_write_w,
  input  logic [ADDRESS_WIDTH-1:0] rd_w,
  input  logic [DATA_WIDTH-1:0]    result_w,
  output logic [DATA_WIDTH-1:0]    operand
);

`ifdef DECODE_EXECUTE_WB_BYPASS_EN
  always_comb begin
    operand = rd;
    // rs != 0 already excludes rd_w == 0 from matching
    if (rs == '0)
      operand = '0;
    else if (reg_write_w && (rd_w == rs))
      operand = result_w;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{reg_write_w, rd_w, result_w};

  always_comb begin
    operand = rd;
    if (rs == '0)
      operand = '0;
  end
`endif

endmodule

// File: rtl/decode_execute_register.sv
// Decode->execute pipeline register with stall, flush and write-back operand bypass.
// Bypass is compiled in when DECODE_EXECUTE_WB_BYPASS_EN is defined.
module decode_execute_register
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 5,
  parameter int ALU_CTRL_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_d,
  input  logic                      flush_e,
  input  logic                      valid_d,
  input  logic [DATA_WIDTH-1:0]     rd1_d,
  input  logic [DATA_WIDTH-1:0]     rd2_d,
  input  logic [ADDRESS_WIDTH-1:0]  rs1_d,
  input  logic [ADDRESS_WIDTH-1:0]  rs2_d,
  input  logic [ADDRESS_WIDTH-1:0]  rd_d,
  input  logic [DATA_WIDTH-1:0]     imm_ext_d,
  input  logic [DATA_WIDTH-1:0]     pc_d,
  input  logic [DATA_WIDTH-1:0]     pc_plus4_d,
  input  logic                      reg_write_d,
  input  logic                      mem_write_d,
  input  logic                      jump_d,
  input  logic                      branch_d,
  input  logic                      alu_src_d,
  input  logic [1:0]                result_src_d,
  input  logic [ALU_CTRL_WIDTH-1:0] alu_control_d,
  input  logic                      reg_write_w,
  input  logic [ADDRESS_WIDTH-1:0]  rd_w,
  input  logic [DATA_WIDTH-1:0]     result_w,
  output logic                      valid_e,
  output logic [DATA_WIDTH-1:0]     rd1_e,
  output logic [DATA_WIDTH-1:0]     rd2_e,
  output logic [ADDRESS_WIDTH-1:0]  rs1_e,
  output logic [ADDRESS_WIDTH-1:0]  rs2_e,
  output logic [ADDRESS_WIDTH-1:0]  rd_e,
  output logic [DATA_WIDTH-1:0]     imm_ext_e,
  output logic [DATA_WIDTH-1:0]     pc_e,
  output logic [DATA_WIDTH-1:0]     pc_plus4_e,
  output logic                      reg_write_e,
  output logic                      mem_write_e,
  output logic                      jump_e,
  output logic                      branch_e,
  output logic                      alu_src_e,
  output logic [1:0]                result_src_e,
  output logic [ALU_CTRL_WIDTH-1:0] alu_control_e
);

  logic [DATA_WIDTH-1:0] op1, op2;
  ctrl_t ctrl_next, ctrl_q;

  operand_bypass #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH)) u_bypass1 (
    .rs(rs1_d), .rd(rd1_d), .reg_write_w(reg_write_w), .rd_w(rd_w),
    .result_w(result_w), .operand(op1)
  );

  operand_bypass #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH)) u_bypass2 (
    .rs(rs2_d), .rd(rd2_d), .reg_write_w(reg_write_w), .rd_w(rd_w),
    .result_w(result_w), .operand(op2)
  );

  // Side-effecting controls are dropped for an empty decode slot
  always_comb begin
    ctrl_next             = NOP_CTRL;
    ctrl_next.reg_write   = reg_write_d & valid_d;
    ctrl_next.mem_write   = mem_write_d & valid_d;
    ctrl_next.jump        = jump_d & valid_d;
    ctrl_next.branch      = branch_d & valid_d;
    ctrl_next.alu_src     = alu_src_d;
    ctrl_next.result_src  = result_src_t'(result_src_d);
    ctrl_next.alu_control = ALU_CTRL_W'(alu_control_d);
  end

  always_ff @(posedge clk) begin
    if (rst || flush_e) begin
      valid_e    <= 1'b0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      rs1_e      <= '0;
      rs2_e      <= '0;
      rd_e       <= '0;
      imm_ext_e  <= '0;
      pc_e       <= '0;
      pc_plus4_e <= '0;
      ctrl_q     <= NOP_CTRL;
    end else if (!stall_d) begin
      valid_e    <= valid_d;
      rd1_e      <= op1;
      rd2_e      <= op2;
      rs1_e      <= rs1_d;
      rs2_e      <= rs2_d;
      rd_e       <= rd_d;
      imm_ext_e  <= imm_ext_d;
      pc_e       <= pc_d;
      pc_plus4_e <= pc_plus4_d;
      ctrl_q     <= ctrl_next;
    end
  end

  assign reg_write_e   = ctrl_q.reg_write;
  assign mem_write_e   = ctrl_q.mem_write;
  assign jump_e        = ctrl_q.jump;
  assign branch_e      = ctrl_q.branch;
  assign alu_src_e     = ctrl_q.alu_src;
  assign result_src_e  = ctrl_q.result_src;
  assign alu_control_e = ALU_CTRL_WIDTH'(ctrl_q.alu_control);

endmodule

// File: tb/tb_decode_execute_register.sv
// Self-checking bench for decode_execute_register: directed plan steps, then random traffic
// against a behavioural model that follows DECODE_EXECUTE_WB_BYPASS_EN like the RTL build.
module tb_decode_execute_register;

  logic        clk = 1'b0;
  logic        rst, stall_d, flush_e, valid_d;
  logic [31:0] rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d, result_w;
  logic [4:0]  rs1_d, rs2_d, rd_d, rd_w;
  logic        reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d, reg_write_w;
  logic [1:0]  result_src_d;
  logic [3:0]  alu_control_d;

  logic        valid_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e;
  logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [1:0]  result_src_e;
  logic [3:0]  alu_control_e;

  // Model state: what the execute side should hold
  logic        m_valid, m_rw, m_mw, m_jump, m_branch, m_alu_src;
  logic [31:0] m_rd1, m_rd2, m_imm, m_pc, m_pc4;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [1:0]  m_rsrc;
  logic [3:0]  m_aluc;

  int unsigned tests = 0;
  int unsigned fails = 0;

`ifdef DECODE_EXECUTE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  decode_execute_register #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5), .ALU_CTRL_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .stall_d(stall_d), .flush_e(flush_e), .valid_d(valid_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .imm_ext_d(imm_ext_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .reg_write_d(reg_write_d), .mem_write_d(mem_write_d), .jump_d(jump_d),
    .branch_d(branch_d), .alu_src_d(alu_src_d), .result_src_d(result_src_d),
    .alu_control_d(alu_control_d), .reg_write_w(reg_write_w), .rd_w(rd_w),
    .result_w(result_w), .valid_e(valid_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e),
    .pc_plus4_e(pc_plus4_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .jump_e(jump_e), .branch_e(branch_e), .alu_src_e(alu_src_e),
    .result_src_e(result_src_e), .alu_control_e(alu_control_e)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_operand(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return 32'd0;
    if (BYPASS && reg_write_w && rd_w == rs) return result_w;
    return rf;
  endfunction

  // Advance the model by one edge using the inputs currently driven
  task automatic model_edge();
    if (rst || flush_e) begin
      {m_valid, m_rw, m_mw, m_jump, m_branch, m_alu_src} = '0;
      {m_rd1, m_rd2, m_imm, m_pc, m_pc4} = '0;
      {m_rs1, m_rs2, m_rd, m_rsrc, m_aluc} = '0;
    end else if (!stall_d) begin
      m_valid = valid_d;
      m_rd1 = model_operand(rs1_d, rd1_d);
      m_rd2 = model_operand(rs2_d, rd2_d);
      m_rs1 = rs1_d; m_rs2 = rs2_d; m_rd = rd_d;
      m_imm = imm_ext_d; m_pc = pc_d; m_pc4 = pc_plus4_d;
      m_rw = valid_d ? reg_write_d : 1'b0;
      m_mw = valid_d ? mem_write_d : 1'b0;
      m_jump = valid_d ? jump_d : 1'b0;
      m_branch = valid_d ? branch_d : 1'b0;
      m_alu_src = alu_src_d; m_rsrc = result_src_d; m_aluc = alu_control_d;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("valid_e", 32'(valid_e), 32'(m_valid));
    check("rd1_e", rd1_e, m_rd1);
    check("rd2_e", rd2_e, m_rd2);
    check("rs1_e", 32'(rs1_e), 32'(m_rs1));
    check("rs2_e", 32'(rs2_e), 32'(m_rs2));
    check("rd_e", 32'(rd_e), 32'(m_rd));
    check("imm_ext_e", imm_ext_e, m_imm);
    check("pc_e", pc_e, m_pc);
    check("pc_plus4_e", pc_plus4_e, m_pc4);
    check("reg_write_e", 32'(reg_write_e), 32'(m_rw));
    check("mem_write_e", 32'(mem_write_e), 32'(m_mw));
    check("jump_e", 32'(jump_e), 32'(m_jump));
    check("branch_e", 32'(branch_e), 32'(m_branch));
    check("alu_src_e", 32'(alu_src_e), 32'(m_alu_src));
    check("result_src_e", 32'(result_src_e), 32'(m_rsrc));
    check("alu_control_e", 32'(alu_control_e), 32'(m_aluc));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic randomize_d();
    valid_d = ($urandom_range(0, 3) != 0);
    rd1_d = $urandom; rd2_d = $urandom;
    rs1_d = 5'($urandom_range(0, 31)); rs2_d = 5'($urandom_range(0, 31));
    rd_d = 5'($urandom_range(0, 31));
    imm_ext_d = $urandom; pc_d = $urandom; pc_plus4_d = pc_d + 32'd4;
    {reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d} = 5'($urandom);
    result_src_d = 2'($urandom_range(0, 2));
    alu_control_d = 4'($urandom);
    reg_write_w = $urandom_range(0, 1) == 1;
    case ($urandom_range(0, 3))
      0: rd_w = rs1_d;
      1: rd_w = rs2_d;
      2: rd_w = 5'd0;
      default: rd_w = 5'($urandom_range(0, 31));
    endcase
    result_w = $urandom;
  endtask

  initial begin
    rst = 1'b1; stall_d = 1'b0; flush_e = 1'b0;
    randomize_d();
    @(negedge clk);

    // Reset for two cycles with random inputs
    tick();
    randomize_d();
    tick();
    check("reset_valid", 32'(valid_e), 32'd0);
    rst = 1'b0;

    // Plain load
    randomize_d();
    valid_d = 1'b1; rs1_d = 5'd5; rd1_d = 32'h1234; reg_write_w = 1'b0;
    reg_write_d = 1'b1; mem_write_d = 1'b0; jump_d = 1'b1; branch_d = 1'b0;
    tick();
    check("load_rd1", rd1_e, 32'h1234);
    check("load_rs1", 32'(rs1_e), 32'd5);

    // Same-cycle write-back bypass
    randomize_d();
    valid_d = 1'b1; rs2_d = 5'd7; rd2_d = 32'hAAAA;
    reg_write_w = 1'b1; rd_w = 5'd7; result_w = 32'h5555;
    tick();
    check("bypass_rd2", rd2_e, BYPASS ? 32'h5555 : 32'hAAAA);

    // x0 is never bypassed and reads as zero
    randomize_d();
    rs1_d = 5'd0; rd1_d = 32'hDEAD; rd_w = 5'd0; reg_write_w = 1'b1; result_w = 32'hBEEF;
    tick();
    check("x0_rd1", rd1_e, 32'd0);

    // Stall holds, then stall+flush loads a bubble
    randomize_d();
    valid_d = 1'b1; reg_write_d = 1'b1; pc_d = 32'h100;
    tick();
    stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_d();
      tick();
      check("stall_pc", pc_e, 32'h100);
    end
    flush_e = 1'b1;
    tick();
    check("flush_valid", 32'(valid_e), 32'd0);
    check("flush_reg_write", 32'(reg_write_e), 32'd0);
    check("flush_pc", pc_e, 32'd0);
    stall_d = 1'b0; flush_e = 1'b0;

    // Release of stall re-evaluates bypass against current write-back inputs
    randomize_d();
    stall_d = 1'b1; tick();
    stall_d = 1'b0;
    rs1_d = 5'd9; rd1_d = 32'h1111; reg_write_w = 1'b1; rd_w = 5'd9; result_w = 32'h2222;
    tick();
    check("release_rd1", rd1_e, BYPASS ? 32'h2222 : 32'h1111);

    // Empty decode slot drops side-effecting controls
    randomize_d();
    valid_d = 1'b0; reg_write_d = 1'b1; mem_write_d = 1'b1;
    tick();
    check("invalid_reg_write", 32'(reg_write_e), 32'd0);
    check("invalid_mem_write", 32'(mem_write_e), 32'd0);
    check("invalid_valid", 32'(valid_e), 32'd0);

    // Reset mid-stall with flush
    randomize_d(); tick();
    stall_d = 1'b1; flush_e = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; flush_e = 1'b0; stall_d = 1'b0;

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      randomize_d();
      stall_d = ($urandom_range(0, 4) == 0);
      flush_e = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_execute_register.md
# decode_execute_register

Pipeline register between the decode stage (register file read, immediate extension, control decode) and the execute stage. It captures RD1/RD2, the decoded instruction fields and the control bundle on each rising edge, and supports stall (hold) and flush (bubble insertion) from the hazard unit. It also applies a write-back bypass: it corrects operands read from the register file in the same cycle that write-back is writing them, because the register file commits writes only on the clock edge.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/PC/immediate width
- ADDRESS_WIDTH, 5, register index width
- ALU_CTRL_WIDTH, 4, ALU control field width

Ports:
- Clocking: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- stall_d  input  1  hold current contents
- flush_e  input  1  load a bubble
- valid_d  input  1  decode slot holds a real instruction
- rd1_d, rd2_d  input  DATA_WIDTH  register file read data
- rs1_d, rs2_d, rd_d  input  ADDRESS_WIDTH  source/destination indices
- imm_ext_d, pc_d, pc_plus4_d  input  DATA_WIDTH  extended immediate, PC, PC+4
- reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d  input  1 each  control
- result_src_d  input  2  result select
- alu_control_d  input  ALU_CTRL_WIDTH  ALU op
- reg_write_w  input  1  write-back enable (same as register file WE3)
- rd_w  input  ADDRESS_WIDTH  write-back index (A3)
- result_w  input  DATA_WIDTH  write-back data (WD3)
- All decode-side fields have matching outputs with an _e suffix (rd1_e, rd2_e, rs1_e, …, alu_control_e), plus valid_e (output, 1).

## Operation
- Priority per edge: rst > flush_e > stall_d > load.
- rst: every output goes to 0, including valid_e. A zero bundle is a NOP: no register write and no memory write.
- flush_e: load a bubble. valid_e, reg_write_e, mem_write_e, jump_d/branch-derived outputs and every other output go to 0. This applies even if stall_d is high in the same cycle.
- stall_d (no flush): every output holds its value. Bypass is not evaluated.
- load: every _d field is copied to its _e output. valid_e is set from valid_d.
- Control outputs are gated by valid_d: when valid_d = 0, reg_write_e, mem_write_e, jump_e and branch_e are loaded as 0.
- Operand capture on load, for each operand (rs1/rd1 and rs2/rd2):
  - rs = 0: capture 0, regardless of the register file contents.
  - Otherwise, if the bypass is compiled in, reg_write_w = 1 and rd_w = rs: capture result_w.
  - Otherwise: capture rd from the register file.
- rd_w = 0 never bypasses.
- No arithmetic is performed; all widths pass through unchanged.

## Timing
- Latency is one cycle: decode-side values appear on the outputs after the next rising edge.
- Everything is purely registered: no combinational path from any input to any output.
- Reset mid-stall or mid-flush: rst wins and the bubble state results.
- Simultaneous load and write-back to the same index: the output carries the new value (result_w) after the edge.
- Release of a stall: the first load edge re-evaluates the bypass against the current write-back inputs.

## Configuration
- DECODE_EXECUTE_WB_BYPASS_EN
  - Defined: same-cycle write-back bypass is active as described above.
  - Undefined: operands always come from the register file (except the x0 forcing). In this build the hazard unit must stall decode one extra cycle on a decode-read / write-back-write match.

## Structure
Shared package pipeline_pkg holds:
- a packed struct for the control bundle (reg_write, mem_write, jump, branch, alu_src, result_src, alu_control);
- an enum for result_src values (ALU, MEM, PC_PLUS4);
- a localparam for the NOP bundle.

Sub-module operand_bypass is the per-operand select: x0 forcing plus the bypass compare. It is combinational and instantiated twice. The flops live in the top module.

## Test plan
- Reset: rst = 1 for 2 cycles with random inputs → all outputs 0, valid_e = 0.
- Plain load: rs1_d = 5, rd1_d = 0x1234, reg_write_w = 0 → next cycle rd1_e = 0x1234, rs1_e = 5, control copied.
- Bypass: rs2_d = 7, rd2_d = 0xAAAA, reg_write_w = 1, rd_w = 7, result_w = 0x5555 → rd2_e = 0x5555 with the macro, 0xAAAA without it.
- x0: rs1_d = 0, rd1_d = 0xDEAD, rd_w = 0, reg_write_w = 1, result_w = 0xBEEF → rd1_e = 0.
- Stall then flush: load pc_d = 0x100; hold stall_d = 1 for 3 cycles while pc_d changes → pc_e stays 0x100; then assert stall_d = 1 and flush_e = 1 together → valid_e = 0, reg_write_e = 0, pc_e = 0.
- Invalid slot: valid_d = 0, reg_write_d = 1, mem_write_d = 1 → reg_write_e = 0, mem_write_e = 0, valid_e = 0.
